// File: rtl/tych_egr_arb.sv
// Packet-level round-robin arbiter sharing one Avalon-ST egress stream among NUM_PORTS requesters.
// A grant is held SOP..EOP; an enable mask and a runaway-packet watchdog constrain grants.
module tych_egr_arb #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DWIDTH    = 64,
  parameter int unsigned EWIDTH    = 3,
  parameter int unsigned MAX_BEATS = 2048
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS*DWIDTH-1:0]  in_data,
  input  logic [NUM_PORTS-1:0]         in_valid,
  input  logic [NUM_PORTS-1:0]         in_sop,
  input  logic [NUM_PORTS-1:0]         in_eop,
  input  logic [NUM_PORTS*EWIDTH-1:0]  in_empty,
  output logic [NUM_PORTS-1:0]         in_ready,
  output logic [DWIDTH-1:0]            out_data,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [EWIDTH-1:0]            out_empty,
  input  logic                         out_ready,
  input  logic [NUM_PORTS-1:0]         cfg_en_mask,
  output logic                         wdog_evt,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id
);

  localparam int unsigned GW = $clog2(NUM_PORTS);
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {StIdle, StArb, StXfer} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ov_q, ov_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic [EWIDTH-1:0]   empty_q, empty_d;
  logic                wdog_q, wdog_d;

  logic [NUM_PORTS-1:0] elig;
  logic                 pick_found;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        cand;

  // Search from the round-robin pointer upward, wrapping to 0.
  always_comb begin
    elig       = in_valid & in_sop & cfg_en_mask;
    pick_found = 1'b0;
    pick       = rr_q;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = GW'((32'(rr_q) + k) % NUM_PORTS);
      if (!pick_found && elig[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  logic              g_valid, g_sop, g_eop;
  logic [DWIDTH-1:0] g_data;
  logic [EWIDTH-1:0] g_empty;

  always_comb begin
    g_valid = 1'b0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_data  = '0;
    g_empty = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == GW'(i)) begin
        g_valid = in_valid[i];
        g_sop   = in_sop[i];
        g_eop   = in_eop[i];
        g_data  = in_data[i*DWIDTH +: DWIDTH];
        g_empty = in_empty[i*EWIDTH +: EWIDTH];
      end
    end
  end

  logic xfer, can_load, accept, wdog_fire;
  logic [CW-1:0] cnt_inc;
  logic [NUM_PORTS-1:0] rdy;

  assign xfer     = (state_q == StXfer);
  assign can_load = ~ov_q | out_ready;
  assign accept   = xfer & g_valid & can_load;

  // Ungranted non-SOP beats are swallowed so stray fragments cannot block a port.
  always_comb begin
    rdy = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (xfer && (grant_q == GW'(i))) rdy[i] = can_load;
      else                             rdy[i] = in_valid[i] & ~in_sop[i];
    end
    in_ready = rst ? rdy : '0;
  end

  always_comb begin
    if (g_sop)                            cnt_inc = CW'(1);
    else if (cnt_q == CW'(MAX_BEATS))     cnt_inc = cnt_q;
    else                                  cnt_inc = cnt_q + CW'(1);
    wdog_fire = accept & ~g_eop & (cnt_inc == CW'(MAX_BEATS));
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (|elig) state_d = StArb;
      StArb: begin
        if (pick_found) begin
          state_d = StXfer;
          grant_d = pick;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StXfer: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (g_eop || wdog_fire) begin
            state_d = StIdle;
            rr_d    = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + GW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ov_d    = ov_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    empty_d = empty_q;
    wdog_d  = 1'b0;
    if (accept) begin
      ov_d    = 1'b1;
      data_d  = g_data;
      sop_d   = g_sop;
      eop_d   = g_eop | wdog_fire;
      empty_d = wdog_fire ? '0 : g_empty;
      wdog_d  = wdog_fire;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      empty_q <= empty_d;
      wdog_q  <= wdog_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = data_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_empty = empty_q;
  assign wdog_evt  = wdog_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_tych_egr_arb.sv
// Scoreboard bench for tych_egr_arb: packet-level round-robin model feeds an expected-beat queue,
// an independent monitor pops and compares every egress handshake.
module tb_tych_egr_arb;
  localparam int NP = 2;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int MB = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]    in_valid, in_sop, in_eop, in_ready, cfg_en_mask;
  logic [NP*EW-1:0] in_empty;
  logic [DW-1:0]    out_data;
  logic             out_valid, out_sop, out_eop, out_ready, wdog_evt;
  logic [EW-1:0]    out_empty;
  logic [0:0]       grant_id;

  always #5 clk = ~clk;

  tych_egr_arb #(.NUM_PORTS(NP), .DWIDTH(DW), .EWIDTH(EW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_ready(out_ready), .cfg_en_mask(cfg_en_mask), .wdog_evt(wdog_evt), .grant_id(grant_id)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    int            port;
  } beat_t;

  beat_t drv_q[NP][$];
  beat_t mdl_q[NP][$];
  beat_t exp_q[$];

  int tests = 0, fails = 0;
  int tb_rr = 0;
  int wd_exp = 0, wd_high = 0, wd_rise = 0;
  bit drv_en = 0, mon_en = 0, gap_en = 0;
  int ordy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic add_pkt(input int p, input int len, input bit with_eop, input int emp);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = {$urandom, $urandom};
      b.sop   = (i == 0);
      b.eop   = with_eop && (i == len - 1);
      b.empty = '0;
      if (b.eop) b.empty = (emp >= 0) ? EW'(emp) : EW'($urandom_range(0, 7));
      b.port  = p;
      drv_q[p].push_back(b);
      mdl_q[p].push_back(b);
    end
  endtask

  // Reference: grant whole packets in round-robin order among masked ports with work pending;
  // a packet reaching MB beats without EOP is cut there and its tail is discarded.
  task automatic sched(input logic [NP-1:0] mask);
    int pick, n, idx;
    beat_t b;
    bit done;
    forever begin
      pick = -1;
      for (int k = 0; k < NP; k++) begin
        idx = (tb_rr + k) % NP;
        if (pick < 0 && mask[idx] && mdl_q[idx].size() > 0) pick = idx;
      end
      if (pick < 0) break;
      n = 0;
      done = 0;
      while (!done) begin
        b = mdl_q[pick].pop_front();
        n++;
        if (!b.eop && n == MB) begin
          b.eop = 1'b1;
          b.empty = '0;
          wd_exp++;
        end
        done = b.eop;
        exp_q.push_back(b);
      end
      while (mdl_q[pick].size() > 0 && !mdl_q[pick][0].sop) void'(mdl_q[pick].pop_front());
      tb_rr = (pick + 1) % NP;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
      busy = (drv_q[0].size() > 0) || (drv_q[1].size() > 0) || (exp_q.size() > 0) || out_valid;
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL timeout: %0d beats still expected, required 0", exp_q.size());
      exp_q.delete();
      for (int p = 0; p < NP; p++) begin
        drv_q[p].delete();
        mdl_q[p].delete();
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // Input driver: handshakes sampled on the falling edge, new values driven just after rising edge.
  initial begin
    bit hs[NP];
    beat_t b;
    int ocnt;
    ocnt = 0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) hs[p] = in_valid[p] & in_ready[p];
      @(posedge clk);
      #1;
      if (drv_en) begin
        for (int p = 0; p < NP; p++) begin
          if (hs[p] && drv_q[p].size() > 0) void'(drv_q[p].pop_front());
          if (drv_q[p].size() > 0) begin
            b = drv_q[p][0];
            in_valid[p] = b.sop || !gap_en || ($urandom_range(0, 3) != 0);
            in_sop[p]   = b.sop;
            in_eop[p]   = b.eop;
            in_data[p*DW +: DW]  = b.data;
            in_empty[p*EW +: EW] = b.empty;
          end else begin
            in_valid[p] = 1'b0;
            in_sop[p]   = 1'b0;
            in_eop[p]   = 1'b0;
          end
        end
        ocnt++;
        case (ordy_mode)
          1:       out_ready = 1'($urandom_range(0, 1));
          2:       out_ready = (ocnt % 3 == 0);
          default: out_ready = 1'b1;
        endcase
      end
    end
  end

  // Monitor: stability under stall, scoreboard pop on handshake, watchdog pulse accounting.
  initial begin
    bit stalled, wd_prev;
    logic [DW-1:0] pd;
    logic ps, pe;
    logic [EW-1:0] pm;
    beat_t e;
    stalled = 0;
    wd_prev = 0;
    forever begin
      @(negedge clk);
      if (wdog_evt) wd_high++;
      if (wdog_evt && !wd_prev) wd_rise++;
      wd_prev = wdog_evt;
      if (mon_en) begin
        if (stalled) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", out_data, pd);
          check("stall_ctl", {59'd0, out_sop, out_eop, out_empty}, {59'd0, ps, pe, pm});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got data %0h, required no beat", out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_sop", 64'(out_sop), 64'(e.sop));
            check("out_eop", 64'(out_eop), 64'(e.eop));
            check("out_empty", 64'(out_empty), 64'(e.empty));
            if (ordy_mode == 0 && e.sop) check("grant_id", 64'(grant_id), 64'(e.port));
          end
        end
        stalled = out_valid && !out_ready;
        pd = out_data;
        ps = out_sop;
        pe = out_eop;
        pm = out_empty;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0;
    in_data = '0;
    in_empty = '0;
    in_valid = '1;
    in_sop = '1;
    in_eop = '0;
    cfg_en_mask = '1;
    out_ready = 1'b1;

    // Reset held with every requester presenting SOP.
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_grant_id", 64'(grant_id), 64'd0);
      check("rst_wdog", 64'(wdog_evt), 64'd0);
    end
    in_valid = '0;
    in_sop = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    drv_en = 1;
    mon_en = 1;

    // Fairness: both saturated with 4-beat packets.
    for (int i = 0; i < 4; i++) begin
      add_pkt(0, 4, 1, -1);
      add_pkt(1, 4, 1, -1);
    end
    sched('1);
    wait_done(400);

    // Backpressure: 5-beat packet, out_ready 1,0,0 pattern, empty 3.
    ordy_mode = 2;
    add_pkt(0, 5, 1, 3);
    sched('1);
    wait_done(200);
    ordy_mode = 0;

    // Mask: only req1 eligible, then switch mask mid-packet.
    cfg_en_mask = 2'b10;
    add_pkt(1, 6, 1, -1);
    add_pkt(0, 3, 1, -1);
    sched(2'b10);
    sched(2'b01);
    n = 0;
    while (!(out_valid && out_sop) && n < 50) begin
      @(negedge clk);
      n++;
    end
    cfg_en_mask = 2'b01;
    wait_done(200);
    cfg_en_mask = 2'b11;

    // Watchdog: 12 beats without EOP on req1, then req0, then an exact MB-beat packet.
    add_pkt(1, 12, 0, -1);
    add_pkt(0, 3, 1, -1);
    add_pkt(1, MB, 1, -1);
    sched('1);
    wait_done(300);
    check("wdog_pulses", 64'(wd_rise), 64'(wd_exp));
    check("wdog_width", 64'(wd_high), 64'(wd_exp));

    // Stray non-SOP beats on req0 while idle must be drained with no egress.
    begin
      beat_t b;
      for (int i = 0; i < 2; i++) begin
        b.data = {$urandom, $urandom};
        b.sop = 1'b0;
        b.eop = 1'b0;
        b.empty = '0;
        b.port = 0;
        drv_q[0].push_back(b);
      end
    end
    n = 0;
    while (!in_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stray_ready", 64'(in_ready[0]), 64'd1);
    wait_done(50);
    check("stray_no_out", 64'(out_valid), 64'd0);
    add_pkt(0, 2, 1, -1);
    sched('1);
    wait_done(100);

    // Random traffic, random backpressure and mid-packet valid gaps.
    ordy_mode = 1;
    gap_en = 1;
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < NP; p++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) add_pkt(p, $urandom_range(1, MB), 1, -1);
      end
      sched('1);
      wait_done(3000);
    end
    check("wdog_total", 64'(wd_rise), 64'(wd_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
